id_ex_pipe: RTL and testbench
=============================

// Module: id_ex_pipe
// PURPOSE
//  Parametrised ID->EX pipeline stage with valid/ready handshake, stall and flush.
//  Sits between decode and execute, and replaces the plain always-load ID/EX register.
//  Empty slots are presented to EX as a safe bubble: NOP instruction, no writeback.
//  Optional skid buffer registers in_ready so that the stall path does not propagate
//  combinationally back into ID.
// PARAMETERS
//  XLEN        32        width of op1/op2/ins/ins_addr
//  REG_ADDR_W  5         width of rd_addr
//  NOP_INS     32'h13    instruction driven when no valid beat is held (addi x0,x0,0)
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous reset, active-low
//  flush        in   1           synchronous squash of all held beats (branch/jump redirect)
//  in_valid     in   1           ID beat valid
//  in_ready     out  1           stage can accept a beat
//  op1          in   XLEN        operand 1 from ID
//  op2          in   XLEN        operand 2 from ID
//  ins          in   XLEN        instruction word from ID
//  ins_addr     in   XLEN        instruction address from ID
//  rd_addr      in   REG_ADDR_W  destination register from ID
//  rd_wen       in   1           writeback enable from ID
//  out_valid    out  1           EX beat valid
//  out_ready    in   1           EX consumes the beat (0 = EX stall)
//  op1_ex, op2_ex, ins_ex, ins_addr_ex  out  XLEN  registered payload to EX
//  rd_addr_ex   out  REG_ADDR_W  registered destination to EX
//  rd_wen_ex    out  1           registered writeback enable, forced 0 when out_valid=0
// BEHAVIOUR
//  - accept = in_valid & in_ready & ~flush; pop = out_valid & out_ready.
//  - Reset (rst=0, async): out_valid=0, op1_ex/op2_ex/ins_addr_ex=0, rd_addr_ex=0,
//    ins_ex=NOP_INS, rd_wen_ex=0, skid empty. in_ready=1 from the first cycle after reset release.
//  - Latency: an accepted beat appears on the outputs the next cycle, in order; no beat is dropped or duplicated.
//  - Stall: while out_valid=1 and out_ready=0, all outputs hold stable.
//  - Pop with no refill: main register loads the bubble (payload 0, ins=NOP_INS, rd_wen=0).
//  - Flush: highest priority. Next cycle out_valid=0, outputs=bubble, skid cleared, and the
//    beat presented with flush is discarded even if in_valid=1. Flush while out_ready=0 still squashes.
//  - rd_wen_ex = out_valid & stored rd_wen at all times.
//  - Reset asserted mid-transfer aborts immediately; all held beats are lost.
// CONFIGURATION
//  SKID_BUF_EN defined: 2-entry buffer (main + skid), FSM EMPTY/BUSY/FULL.
//    in_ready is a flop output, in_ready = (state != FULL).
//    EMPTY: accept->BUSY.
//    BUSY: accept&~pop->FULL (beat into skid); pop&~accept->EMPTY; both or neither->BUSY.
//    FULL: pop->BUSY (skid moves to main); no accept possible.
//    Any state with flush->EMPTY.
//    Sustains 1 beat/cycle with out_ready=1.
//  SKID_BUF_EN undefined: single register, no FSM.
//    in_ready = ~out_valid | out_ready (combinational). accept loads main; pop without accept loads the bubble.
// TESTING
//  1 Reset: drive rst=0 with random inputs -> out_valid=0, ins_ex=32'h13, rd_wen_ex=0, others 0; after release in_ready=1.
//  2 Stream: 8 back-to-back beats (ins=0x00100093+i, ins_addr=4*i), out_ready=1 -> identical sequence
//    one cycle later, no gaps.
//  3 Stall: beat A held, out_ready=0 for 3 cycles, in_valid=1 with B -> A stable on outputs;
//    with SKID_BUF_EN, B parked and in_ready=0; out_ready=1 -> A, then B, in order.
//  4 Flush: 2 beats held (FULL), flush=1 with in_valid=1 beat C -> next cycle out_valid=0,
//    ins_ex=32'h13, rd_wen_ex=0; C never appears.
//  5 Drain: single beat with rd_wen=1, rd_addr=5 popped with in_valid=0 -> next cycle
//    out_valid=0, rd_wen_ex=0, ins_ex=32'h13.
//  6 Async reset mid-stall: drop rst between clock edges while FULL -> outputs reach reset
//    values before the next edge.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID->EX stage: one-cycle registered payload with valid/ready; empty slots present a NOP bubble.
// Latency 1 cycle; flush squashes everything held; `SKID_BUF_EN adds a skid entry so in_ready_o is a flop.
// Backpressure: out_ready_i=0 holds outputs stable; in_ready_o drops when no slot is free.
module id_ex_pipe #(
   parameter int              XLEN       = 32,
   parameter int              REG_ADDR_W = 5,
   parameter logic [XLEN-1:0] NOP_INS    = 32'h13
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [XLEN-1:0]       op1_i,
   input  logic [XLEN-1:0]       op2_i,
   input  logic [XLEN-1:0]       ins_i,
   input  logic [XLEN-1:0]       ins_addr_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic                  rd_wen_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [XLEN-1:0]       op1_ex_o,
   output logic [XLEN-1:0]       op2_ex_o,
   output logic [XLEN-1:0]       ins_ex_o,
   output logic [XLEN-1:0]       ins_addr_ex_o,
   output logic [REG_ADDR_W-1:0] rd_addr_ex_o,
   output logic                  rd_wen_ex_o
);

   typedef struct packed {
      logic [XLEN-1:0]       op1;
      logic [XLEN-1:0]       op2;
      logic [XLEN-1:0]       ins;
      logic [XLEN-1:0]       ins_addr;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic                  rd_wen;
   } beat_t;

   localparam beat_t BUBBLE = '{op1: '0, op2: '0, ins: NOP_INS, ins_addr: '0,
                                rd_addr: '0, rd_wen: 1'b0};

   beat_t in_beat;
   beat_t main_q;
   logic  out_valid_q;
   logic  accept;
   logic  pop;

   assign in_beat = '{op1: op1_i, op2: op2_i, ins: ins_i, ins_addr: ins_addr_i,
                      rd_addr: rd_addr_i, rd_wen: rd_wen_i};

   assign accept = in_valid_i & in_ready_o & ~flush_i;
   assign pop    = out_valid_q & out_ready_i;

`ifdef SKID_BUF_EN
   typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

   state_t state_q;
   beat_t  skid_q;
   logic   in_ready_q;

   assign in_ready_o = in_ready_q;

   // in_ready_q tracks (next state != FULL) so ID never sees the EX stall combinationally
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= EMPTY;
         main_q      <= BUBBLE;
         skid_q      <= BUBBLE;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else if (flush_i) begin
         state_q     <= EMPTY;
         main_q      <= BUBBLE;
         skid_q      <= BUBBLE;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_q      <= in_beat;
                  out_valid_q <= 1'b1;
                  state_q     <= BUSY;
               end
            end
            BUSY: begin
               case ({accept, pop})
                  2'b11: main_q <= in_beat;
                  2'b10: begin
                     skid_q     <= in_beat;
                     state_q    <= FULL;
                     in_ready_q <= 1'b0;
                  end
                  2'b01: begin
                     main_q      <= BUBBLE;
                     out_valid_q <= 1'b0;
                     state_q     <= EMPTY;
                  end
                  default: ;
               endcase
            end
            FULL: begin
               if (pop) begin
                  main_q     <= skid_q;
                  skid_q     <= BUBBLE;
                  state_q    <= BUSY;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= EMPTY;
               main_q      <= BUBBLE;
               skid_q      <= BUBBLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end
`else
   assign in_ready_o = ~out_valid_q | out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         main_q      <= BUBBLE;
      end else if (flush_i) begin
         out_valid_q <= 1'b0;
         main_q      <= BUBBLE;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         main_q      <= in_beat;
      end else if (pop) begin
         out_valid_q <= 1'b0;
         main_q      <= BUBBLE;
      end
   end
`endif

   assign out_valid_o   = out_valid_q;
   assign op1_ex_o      = main_q.op1;
   assign op2_ex_o      = main_q.op2;
   assign ins_ex_o      = main_q.ins;
   assign ins_addr_ex_o = main_q.ins_addr;
   assign rd_addr_ex_o  = main_q.rd_addr;
   assign rd_wen_ex_o   = out_valid_q & main_q.rd_wen;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, streaming, stall, flush, drain and async reset mid-stall.
// Expected values are hand-computed constants; valid for both the default and SKID_BUF_EN builds.
module tb_id_ex_pipe;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] op1_i, op2_i, ins_i, ins_addr_i;
   logic [4:0]  rd_addr_i;
   logic        rd_wen_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] op1_ex_o, op2_ex_o, ins_ex_o, ins_addr_ex_o;
   logic [4:0]  rd_addr_ex_o;
   logic        rd_wen_ex_o;

   int vectors     = 0;
   int miscompares = 0;

   localparam logic [31:0] NOP = 32'h13;

   id_ex_pipe dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .op1_i        (op1_i),
      .op2_i        (op2_i),
      .ins_i        (ins_i),
      .ins_addr_i   (ins_addr_i),
      .rd_addr_i    (rd_addr_i),
      .rd_wen_i     (rd_wen_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .op1_ex_o     (op1_ex_o),
      .op2_ex_o     (op2_ex_o),
      .ins_ex_o     (ins_ex_o),
      .ins_addr_ex_o(ins_addr_ex_o),
      .rd_addr_ex_o (rd_addr_ex_o),
      .rd_wen_ex_o  (rd_wen_ex_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ins, input logic [31:0] addr,
                        input logic [4:0] rd, input logic w);
      in_valid_i = v;
      op1_i      = a;
      op2_i      = b;
      ins_i      = ins;
      ins_addr_i = addr;
      rd_addr_i  = rd;
      rd_wen_i   = w;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid_o}, 32'd0);
      check({tag, "_ins"},   ins_ex_o, NOP);
      check({tag, "_wen"},   {31'd0, rd_wen_ex_o}, 32'd0);
      check({tag, "_op1"},   op1_ex_o, 32'd0);
      check({tag, "_rd"},    {27'd0, rd_addr_ex_o}, 32'd0);
   endtask

   initial begin
      // Reset with random inputs toggling
      rst_ni  = 1'b0;
      flush_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom));
         out_ready_i = 1'($urandom);
         tick();
      end
      check_bubble("rst");
      check("rst_op2",  op2_ex_o, 32'd0);
      check("rst_addr", ins_addr_ex_o, 32'd0);
      rst_ni = 1'b1;
      drive(1'b0, 0, 0, 0, 0, 5'd0, 1'b0);
      out_ready_i = 1'b1;
      tick();
      check("rel_in_ready", {31'd0, in_ready_o}, 32'd1);
      check("rel_valid",    {31'd0, out_valid_o}, 32'd0);

      // Back-to-back stream
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'(i * 3), ~32'(i), 32'h00100093 + 32'(i), 32'(4 * i), 5'(i), 1'(i));
         tick();
         check($sformatf("strm%0d_valid", i), {31'd0, out_valid_o}, 32'd1);
         check($sformatf("strm%0d_ins", i),   ins_ex_o, 32'h00100093 + 32'(i));
         check($sformatf("strm%0d_addr", i),  ins_addr_ex_o, 32'(4 * i));
         check($sformatf("strm%0d_op1", i),   op1_ex_o, 32'(i * 3));
         check($sformatf("strm%0d_op2", i),   op2_ex_o, ~32'(i));
         check($sformatf("strm%0d_wen", i),   {31'd0, rd_wen_ex_o}, 32'(i % 2));
         check($sformatf("strm%0d_rdy", i),   {31'd0, in_ready_o}, 32'd1);
      end
      drive(1'b0, 0, 0, 0, 0, 5'd0, 1'b0);
      tick();
      check_bubble("strm_end");

      // Stall: A held while B waits
      drive(1'b1, 32'h1111, 32'h0, 32'h00A00513, 32'h100, 5'd10, 1'b1);
      tick();
      check("stall_A_load", ins_ex_o, 32'h00A00513);
      out_ready_i = 1'b0;
      drive(1'b1, 32'h2222, 32'h0, 32'h00B00593, 32'h104, 5'd11, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("stall%0d_ins", k),   ins_ex_o, 32'h00A00513);
         check($sformatf("stall%0d_op1", k),   op1_ex_o, 32'h1111);
         check($sformatf("stall%0d_valid", k), {31'd0, out_valid_o}, 32'd1);
         check($sformatf("stall%0d_rdy", k),   {31'd0, in_ready_o}, 32'd0);
      end
      out_ready_i = 1'b1;
      tick();
      check("stall_B_ins",  ins_ex_o, 32'h00B00593);
      check("stall_B_op1",  op1_ex_o, 32'h2222);
      check("stall_B_addr", ins_addr_ex_o, 32'h104);
      drive(1'b0, 0, 0, 0, 0, 5'd0, 1'b0);
      tick();
      check_bubble("stall_end");

      // Flush with two beats held and a third presented
      out_ready_i = 1'b0;
      drive(1'b1, 32'h4444, 32'h0, 32'h00D00693, 32'h200, 5'd13, 1'b1);
      tick();
      drive(1'b1, 32'h5555, 32'h0, 32'h00E00713, 32'h204, 5'd14, 1'b1);
      tick();
      check("flush_pre_ins", ins_ex_o, 32'h00D00693);
      flush_i = 1'b1;
      drive(1'b1, 32'h3333, 32'h0, 32'h00C00613, 32'h208, 5'd12, 1'b1);
      tick();
      flush_i = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 5'd0, 1'b0);
      check_bubble("flush");
      out_ready_i = 1'b1;
      tick();
      check("flush_after_valid", {31'd0, out_valid_o}, 32'd0);
      check("flush_after_ins",   ins_ex_o, NOP);

      // Drain: single beat then pop with no refill
      drive(1'b1, 32'h6666, 32'h7777, 32'h00500293, 32'h300, 5'd5, 1'b1);
      tick();
      check("drain_wen",   {31'd0, rd_wen_ex_o}, 32'd1);
      check("drain_rd",    {27'd0, rd_addr_ex_o}, 32'd5);
      check("drain_valid", {31'd0, out_valid_o}, 32'd1);
      drive(1'b0, 0, 0, 0, 0, 5'd0, 1'b0);
      tick();
      check_bubble("drain");

      // Async reset dropped between edges while stalled with two beats
      out_ready_i = 1'b0;
      drive(1'b1, 32'h8888, 32'h0, 32'h00800413, 32'h400, 5'd8, 1'b1);
      tick();
      drive(1'b1, 32'h9999, 32'h0, 32'h00900493, 32'h404, 5'd9, 1'b1);
      tick();
      check("arst_pre_ins", ins_ex_o, 32'h00800413);
      #3;
      rst_ni = 1'b0;
      #1;
      check_bubble("arst");
      drive(1'b0, 0, 0, 0, 0, 5'd0, 1'b0);
      #2;
      rst_ni = 1'b1;
      tick();
      check("arst_rel_rdy",   {31'd0, in_ready_o}, 32'd1);
      check("arst_rel_valid", {31'd0, out_valid_o}, 32'd0);
      out_ready_i = 1'b1;
      drive(1'b1, 32'hAAAA, 32'h0, 32'h00F00793, 32'h500, 5'd15, 1'b0);
      tick();
      check("arst_F_ins",   ins_ex_o, 32'h00F00793);
      check("arst_F_valid", {31'd0, out_valid_o}, 32'd1);
      drive(1'b0, 0, 0, 0, 0, 5'd0, 1'b0);
      tick();
      check_bubble("arst_empty");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
